// File: rtl/data_processor_pkg.sv
// Shared types and defaults for the data processor and the PE array controller.
package data_processor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic [1:0] sym_t;

    localparam int DEF_PE_ARRAY_SIZE = 4;
    localparam int DEF_VEF_BIT       = 12;

    // A stored t entry is {t, v, f}.
    function automatic int tvf_width(input int vef_bit);
        return 2 + 2 * vef_bit;
    endfunction

endpackage

// File: rtl/dp_tvf_ram.sv
// {t,v,f} entry store: one asynchronous read port, one synchronous write port.
module dp_tvf_ram
    import data_processor_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = tvf_width(DEF_VEF_BIT),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_processor.sv
// Loads s/t symbol streams, then serves s in PE-wide chunks and t/v/f entries in passes; head and chunk reads are combinational.
// Consumers pace everything via i_update_s_w / i_t_pop / i_update_t_w; o_err exists only with DATA_PROCESSOR_ERR_EN defined.
module data_processor
    import data_processor_pkg::*;
#(
    parameter int PE_ARRAY_SIZE = DEF_PE_ARRAY_SIZE,
    parameter int S_MAX_LEN     = 1024,
    parameter int T_MAX_LEN     = 256,
    parameter int VEF_BIT       = DEF_VEF_BIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
`ifdef DATA_PROCESSOR_ERR_EN
    output logic                         o_err,
`endif
    input  logic                         i_s_sym_valid,
    input  logic [1:0]                   i_s_sym,
    input  logic                         i_s_sym_last,
    input  logic                         i_t_sym_valid,
    input  logic [1:0]                   i_t_sym,
    input  logic                         i_t_sym_last,
    output logic                         o_data_valid,
    input  logic                         i_update_s_w,
    output logic [PE_ARRAY_SIZE*2-1:0]   o_s,
    output logic                         o_s_last,
    input  logic                         i_t_pop,
    output logic [1:0]                   o_t,
    output logic [VEF_BIT-1:0]           o_v,
    output logic [VEF_BIT-1:0]           o_f,
    output logic                         o_t_last,
    input  logic                         i_update_t_w,
    input  logic [1:0]                   i_t,
    input  logic [VEF_BIT-1:0]           i_v,
    input  logic [VEF_BIT-1:0]           i_f
);

    localparam int SLW = $clog2(S_MAX_LEN + 1);
    localparam int SAW = (S_MAX_LEN > 1) ? $clog2(S_MAX_LEN) : 1;
    localparam int TLW = $clog2(T_MAX_LEN + 1);
    localparam int TAW = (T_MAX_LEN > 1) ? $clog2(T_MAX_LEN) : 1;
    localparam int WW  = tvf_width(VEF_BIT);

    localparam logic [SLW-1:0] S_MAX = SLW'(S_MAX_LEN);
    localparam logic [TLW-1:0] T_MAX = TLW'(T_MAX_LEN);

    state_e          state_q, state_d;
    logic [SLW-1:0]  s_len_q, s_len_d;
    logic [SLW-1:0]  chunk_q, chunk_d;
    logic [TLW-1:0]  t_len_q, t_len_d;
    logic [TLW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [TLW-1:0]  wr_ptr_q, wr_ptr_d;
    logic            s_seen_q, s_seen_d;
    logic            t_seen_q, t_seen_d;
    logic            last_taken_q, last_taken_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dvalid_q, dvalid_d;

    sym_t            s_mem_q [S_MAX_LEN];
    logic            s_we;

    logic            ram_we;
    logic [TAW-1:0]  ram_waddr;
    logic [WW-1:0]   ram_wdata;
    logic [WW-1:0]   ram_rdata;

    logic [31:0]     chunk_base;
    logic            s_last;
    logic            rd_ok;
    logic            wr_ok;

    assign chunk_base = 32'(chunk_q) * 32'(PE_ARRAY_SIZE);
    assign s_last     = (s_len_q != '0)
                     && (32'(s_len_q) > chunk_base)
                     && (32'(s_len_q) <= chunk_base + 32'(PE_ARRAY_SIZE));
    assign rd_ok      = (rd_ptr_q < t_len_q);
    assign wr_ok      = (wr_ptr_q < t_len_q);

    for (genvar k = 0; k < PE_ARRAY_SIZE; k++) begin : g_lane
        logic [31:0] idx;
        assign idx = chunk_base + 32'(k);
        assign o_s[2*k +: 2] = (idx < 32'(s_len_q)) ? s_mem_q[idx[SAW-1:0]] : 2'b00;
    end

    assign o_s_last = s_last;

    dp_tvf_ram #(
        .DEPTH   (T_MAX_LEN),
        .WIDTH   (WW)
    ) u_tvf_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_q[TAW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Past the stored entries the head reads as zero so stale storage never leaks out.
    assign o_t      = rd_ok ? ram_rdata[WW-1 -: 2]                : 2'b00;
    assign o_v      = rd_ok ? ram_rdata[2*VEF_BIT-1 -: VEF_BIT]   : '0;
    assign o_f      = rd_ok ? ram_rdata[VEF_BIT-1:0]              : '0;
    assign o_t_last = rd_ok && ((rd_ptr_q + TLW'(1)) == t_len_q);

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_data_valid = dvalid_q;

    always_comb begin
        state_d      = state_q;
        s_len_d      = s_len_q;
        chunk_d      = chunk_q;
        t_len_d      = t_len_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        s_seen_d     = s_seen_q;
        t_seen_d     = t_seen_q;
        last_taken_d = last_taken_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dvalid_d     = dvalid_q;
        s_we         = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q[TAW-1:0];
        ram_wdata    = {i_t, i_v, i_f};

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d      = ST_LOAD;
                    busy_d       = 1'b1;
                    s_len_d      = '0;
                    chunk_d      = '0;
                    t_len_d      = '0;
                    rd_ptr_d     = '0;
                    wr_ptr_d     = '0;
                    s_seen_d     = 1'b0;
                    t_seen_d     = 1'b0;
                    last_taken_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // A dropped last symbol still closes its stream, so LOAD cannot stall on overflow.
                if (i_s_sym_valid) begin
                    if (s_len_q != S_MAX) begin
                        s_we    = 1'b1;
                        s_len_d = s_len_q + SLW'(1);
                    end
                    if (i_s_sym_last) begin
                        s_seen_d = 1'b1;
                    end
                end
                if (i_t_sym_valid) begin
                    if (t_len_q != T_MAX) begin
                        ram_we    = 1'b1;
                        ram_waddr = t_len_q[TAW-1:0];
                        ram_wdata = {i_t_sym, {(2*VEF_BIT){1'b0}}};
                        t_len_d   = t_len_q + TLW'(1);
                    end
                    if (i_t_sym_last) begin
                        t_seen_d = 1'b1;
                    end
                end
                if (s_seen_d && t_seen_d) begin
                    state_d  = ST_RUN;
                    dvalid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_update_s_w) begin
                    if (s_last) begin
                        last_taken_d = 1'b1;
                    end else begin
                        chunk_d = chunk_q + SLW'(1);
                    end
                end
                if (i_t_pop && rd_ok) begin
                    rd_ptr_d = rd_ptr_q + TLW'(1);
                end
                if (i_update_t_w && wr_ok) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + TLW'(1);
                end
                // Every entry written back: rewind for the next pass, or finish once the last chunk went out.
                if (wr_ptr_q == t_len_q) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    if (last_taken_q) begin
                        state_d  = ST_DONE;
                        dvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_len_q      <= '0;
            chunk_q      <= '0;
            t_len_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            s_seen_q     <= 1'b0;
            t_seen_q     <= 1'b0;
            last_taken_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_len_q      <= s_len_d;
            chunk_q      <= chunk_d;
            t_len_q      <= t_len_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            s_seen_q     <= s_seen_d;
            t_seen_q     <= t_seen_d;
            last_taken_q <= last_taken_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dvalid_q     <= dvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_we) begin
            s_mem_q[s_len_q[SAW-1:0]] <= i_s_sym;
        end
    end

`ifdef DATA_PROCESSOR_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && i_start) begin
            err_d = 1'b0;
        end else if ((state_q == ST_LOAD && ((i_s_sym_valid && s_len_q == S_MAX)
                                          || (i_t_sym_valid && t_len_q == T_MAX)))
                  || (state_q == ST_RUN  && ((i_t_pop && !rd_ok)
                                          || (i_update_t_w && !wr_ok)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_data_processor.sv
// Directed and randomized bench for data_processor against a queue/array reference model.
module tb_data_processor;

    localparam int PE   = 4;
    localparam int SMAX = 16;
    localparam int TMAX = 8;
    localparam int VEF  = 12;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    typedef struct packed {
        logic [1:0]     t;
        logic [VEF-1:0] v;
        logic [VEF-1:0] f;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic              o_busy, o_done;
    logic              i_s_sym_valid, i_s_sym_last;
    logic [1:0]        i_s_sym;
    logic              i_t_sym_valid, i_t_sym_last;
    logic [1:0]        i_t_sym;
    logic              o_data_valid;
    logic              i_update_s_w;
    logic [2*PE-1:0]   o_s;
    logic              o_s_last;
    logic              i_t_pop;
    logic [1:0]        o_t;
    logic [VEF-1:0]    o_v, o_f;
    logic              o_t_last;
    logic              i_update_t_w;
    logic [1:0]        i_t;
    logic [VEF-1:0]    i_v, i_f;
`ifdef DATA_PROCESSOR_ERR_EN
    logic              o_err;
`endif

    always #5 clk = ~clk;

    data_processor #(
        .PE_ARRAY_SIZE (PE),
        .S_MAX_LEN     (SMAX),
        .T_MAX_LEN     (TMAX),
        .VEF_BIT       (VEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
`ifdef DATA_PROCESSOR_ERR_EN
        .o_err         (o_err),
`endif
        .i_s_sym_valid (i_s_sym_valid),
        .i_s_sym       (i_s_sym),
        .i_s_sym_last  (i_s_sym_last),
        .i_t_sym_valid (i_t_sym_valid),
        .i_t_sym       (i_t_sym),
        .i_t_sym_last  (i_t_sym_last),
        .o_data_valid  (o_data_valid),
        .i_update_s_w  (i_update_s_w),
        .o_s           (o_s),
        .o_s_last      (o_s_last),
        .i_t_pop       (i_t_pop),
        .o_t           (o_t),
        .o_v           (o_v),
        .o_f           (o_f),
        .o_t_last      (o_t_last),
        .i_update_t_w  (i_update_t_w),
        .i_t           (i_t),
        .i_v           (i_v),
        .i_f           (i_f)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: transaction-level view of the stored data and read/write positions.
    logic [1:0] m_s [$];
    ent_t       m_t [TMAX];
    int         m_tlen, m_rd, m_wr, m_chunk, m_phase;
    bit         m_last, m_sseen, m_tseen, m_err;

    logic [1:0] sv_a [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0] sv_b [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [1:0] tv   [3] = '{2'd1, 2'd2, 2'd3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2*PE-1:0] exp_s();
        logic [2*PE-1:0] r;
        r = '0;
        for (int k = 0; k < PE; k++) begin
            int idx;
            idx = m_chunk * PE + k;
            if (idx < m_s.size()) r[2*k +: 2] = m_s[idx];
        end
        return r;
    endfunction

    function automatic bit exp_slast();
        return (m_s.size() > 0) && ((m_s.size() - 1) / PE == m_chunk);
    endfunction

    task automatic model_clear();
        m_s.delete();
        m_tlen = 0; m_rd = 0; m_wr = 0; m_chunk = 0;
        m_last = 0; m_sseen = 0; m_tseen = 0;
    endtask

    task automatic model_update();
        if (rst) begin
            model_clear();
            m_phase = P_IDLE;
            m_err   = 0;
            return;
        end
        case (m_phase)
            P_IDLE: if (i_start) begin
                model_clear();
                m_err   = 0;
                m_phase = P_LOAD;
            end
            P_LOAD: begin
                if (i_s_sym_valid) begin
                    if (m_s.size() < SMAX) m_s.push_back(i_s_sym);
                    else m_err = 1;
                    if (i_s_sym_last) m_sseen = 1;
                end
                if (i_t_sym_valid) begin
                    if (m_tlen < TMAX) begin
                        m_t[m_tlen].t = i_t_sym;
                        m_t[m_tlen].v = '0;
                        m_t[m_tlen].f = '0;
                        m_tlen++;
                    end else m_err = 1;
                    if (i_t_sym_last) m_tseen = 1;
                end
                if (m_sseen && m_tseen) m_phase = P_RUN;
            end
            P_RUN: begin
                bit pass_end, was_last, on_last;
                pass_end = (m_wr == m_tlen);
                was_last = m_last;
                on_last  = exp_slast();
                if (i_update_s_w) begin
                    if (on_last) m_last = 1;
                    else m_chunk++;
                end
                if (i_t_pop) begin
                    if (m_rd < m_tlen) m_rd++;
                    else m_err = 1;
                end
                if (i_update_t_w) begin
                    if (m_wr < m_tlen) begin
                        m_t[m_wr].t = i_t;
                        m_t[m_wr].v = i_v;
                        m_t[m_wr].f = i_f;
                        m_wr++;
                    end else m_err = 1;
                end
                if (pass_end) begin
                    m_rd = 0;
                    m_wr = 0;
                    if (was_last) m_phase = P_DONE;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        chk("busy",     32'(o_busy),       32'(m_phase != P_IDLE));
        chk("done",     32'(o_done),       32'(m_phase == P_DONE));
        chk("dvalid",   32'(o_data_valid), 32'(m_phase == P_RUN));
        chk("s_chunk",  32'(o_s),          32'(exp_s()));
        chk("s_last",   32'(o_s_last),     32'(exp_slast()));
        chk("t_last",   32'(o_t_last),     32'((m_tlen > 0) && (m_rd == m_tlen - 1)));
        if (m_rd < m_tlen) begin
            chk("head_t", 32'(o_t), 32'(m_t[m_rd].t));
            chk("head_v", 32'(o_v), 32'(m_t[m_rd].v));
            chk("head_f", 32'(o_f), 32'(m_t[m_rd].f));
        end
`ifdef DATA_PROCESSOR_ERR_EN
        chk("err", 32'(o_err), 32'(m_err));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        check_outputs();
    endtask

    task automatic idle_inputs();
        i_start = 0;
        i_s_sym_valid = 0; i_s_sym = 0; i_s_sym_last = 0;
        i_t_sym_valid = 0; i_t_sym = 0; i_t_sym_last = 0;
        i_update_s_w = 0; i_t_pop = 0; i_update_t_w = 0;
        i_t = 0; i_v = 0; i_f = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(o_busy),       32'd0);
        chk({tag, "_done"},  32'(o_done),       32'd0);
        chk({tag, "_dv"},    32'(o_data_valid), 32'd0);
        chk({tag, "_s"},     32'(o_s),          32'd0);
        chk({tag, "_slast"}, 32'(o_s_last),     32'd0);
        chk({tag, "_t"},     32'(o_t),          32'd0);
        chk({tag, "_v"},     32'(o_v),          32'd0);
        chk({tag, "_f"},     32'(o_f),          32'd0);
        chk({tag, "_tlast"}, 32'(o_t_last),     32'd0);
`ifdef DATA_PROCESSOR_ERR_EN
        chk({tag, "_err"},   32'(o_err),        32'd0);
`endif
    endtask

    task automatic rand_round(input int slen, input int tlen, input int rst_at);
        int si, ti, g;
        i_start = 1; step(); i_start = 0;
        si = 0; ti = 0; g = 0;
        while ((si < slen || ti < tlen) && g < 400) begin
            idle_inputs();
            i_t_pop = 1'($urandom);
            if (si < slen && ($urandom % 3) != 0) begin
                i_s_sym_valid = 1; i_s_sym = 2'($urandom); i_s_sym_last = (si == slen - 1); si++;
            end
            if (ti < tlen && ($urandom % 3) != 0) begin
                i_t_sym_valid = 1; i_t_sym = 2'($urandom); i_t_sym_last = (ti == tlen - 1); ti++;
            end
            step();
            g++;
        end
        idle_inputs();
        for (int n = 0; n < 600 && m_phase != P_IDLE; n++) begin
            i_update_s_w  = (($urandom % 4) == 0);
            i_t_pop       = 1'($urandom);
            i_update_t_w  = 1'($urandom);
            i_t           = 2'($urandom);
            i_v           = VEF'($urandom);
            i_f           = VEF'($urandom);
            i_s_sym_valid = (($urandom % 8) == 0);
            i_t_sym_valid = (($urandom % 8) == 0);
            i_start       = (($urandom % 16) == 0);
            if (n == rst_at) begin
                chk("pre_rst_dv", 32'(o_data_valid), 32'd1);
                rst = 1;
                step();
                rst = 0;
                chk_all_zero("rst_run");
                break;
            end
            step();
        end
        idle_inputs();
        chk("round_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_phase = P_IDLE;
        model_clear();
        m_err = 0;
        step();
        step();
        rst = 0;
        chk_all_zero("reset");

        // Directed: 8 s symbols, 3 t symbols, two passes.
        i_start = 1; step(); i_start = 0;
        for (int i = 0; i < 8; i++) begin
            i_s_sym_valid = 1; i_s_sym = sv_a[i]; i_s_sym_last = (i == 7);
            i_t_sym_valid = (i < 3);
            i_t_sym       = (i < 3) ? tv[i % 3] : 2'd0;
            i_t_sym_last  = (i == 2);
            step();
        end
        idle_inputs();
        chk("dir_dv",     32'(o_data_valid), 32'd1);
        chk("dir_e4",     32'(o_s),          32'hE4);
        chk("dir_slast0", 32'(o_s_last),     32'd0);
        i_update_s_w = 1; step(); i_update_s_w = 0;
        chk("dir_1b",     32'(o_s),          32'h1B);
        chk("dir_slast1", 32'(o_s_last),     32'd1);
        for (int e = 0; e < 3; e++) begin
            chk("p1_t",     32'(o_t),      32'(tv[e]));
            chk("p1_v",     32'(o_v),      32'd0);
            chk("p1_f",     32'(o_f),      32'd0);
            chk("p1_tlast", 32'(o_t_last), 32'(e == 2));
            i_t_pop = 1; i_update_t_w = 1; i_t = tv[e]; i_v = 5; i_f = 3;
            step();
        end
        idle_inputs();
        step();
        chk("p1_end_dv", 32'(o_data_valid), 32'd1);
        for (int e = 0; e < 3; e++) begin
            chk("p2_v", 32'(o_v), 32'd5);
            chk("p2_f", 32'(o_f), 32'd3);
            i_update_s_w = (e == 0);
            i_t_pop = 1; i_update_t_w = 1; i_t = tv[e]; i_v = 7; i_f = 1;
            step();
        end
        idle_inputs();
        step();
        chk("done_pulse", 32'(o_done), 32'd1);
        step();
        chk("done_gone",  32'(o_done), 32'd0);
        chk("busy_gone",  32'(o_busy), 32'd0);

        // Directed: 5 s symbols (partial last chunk) and an over-pop.
        i_start = 1; step(); i_start = 0;
        for (int i = 0; i < 5; i++) begin
            i_s_sym_valid = 1; i_s_sym = sv_b[i]; i_s_sym_last = (i == 4);
            i_t_sym_valid = (i < 3);
            i_t_sym       = (i < 3) ? tv[i % 3] : 2'd0;
            i_t_sym_last  = (i == 2);
            step();
        end
        idle_inputs();
        chk("s5_c0", 32'(o_s), 32'h39);
        i_update_s_w = 1; step(); i_update_s_w = 0;
        chk("s5_c1",    32'(o_s),      32'h02);
        chk("s5_slast", 32'(o_s_last), 32'd1);
        for (int p = 0; p < 4; p++) begin
            i_t_pop = 1; step();
        end
        i_t_pop = 0;
`ifdef DATA_PROCESSOR_ERR_EN
        chk("err_pop4", 32'(o_err), 32'd1);
`endif
        i_update_s_w = 1; step(); i_update_s_w = 0;
        for (int e = 0; e < 3; e++) begin
            i_update_t_w = 1; i_v = 1; i_f = 2; step();
        end
        idle_inputs();
        step();
        chk("s5_done", 32'(o_done), 32'd1);
        step();
`ifdef DATA_PROCESSOR_ERR_EN
        chk("err_held", 32'(o_err), 32'd1);
`endif
        i_start = 1; step(); i_start = 0;
`ifdef DATA_PROCESSOR_ERR_EN
        chk("err_clr", 32'(o_err), 32'd0);
`endif
        // Reset in the middle of LOAD.
        i_s_sym_valid = 1; i_s_sym = 2'd3; step(); step();
        idle_inputs();
        rst = 1; step(); rst = 0;
        chk_all_zero("rst_load");

        // Randomized rounds, including overflowing loads and a reset mid-RUN.
        rand_round(20, 11, -1);
        rand_round(20, 8, 5);
        for (int r = 0; r < 12; r++) begin
            rand_round(int'($urandom_range(1, 20)), int'($urandom_range(1, 11)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
